// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that feeds bytes from NUM_REQ level
// requesters into a single uart_tx, one byte per frame.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset
//   req       per-requester byte-valid level
//   req_data  requester i byte on [8i+7:8i]
//   ack       one-hot, one-cycle pulse: requester's byte taken
//   tx_data   registered byte to uart_tx, held until the next grant
//   tx_send   one-cycle send strobe to uart_tx
//   tx_ready  uart_tx ready, low while a frame is in progress
//   busy      high whenever the FSM is not in IDLE
//   gnt_id    index of the last granted requester
//
// Build option: define UART_ARB_LOCK_EN to keep granting the last winner
// while its req stays high (message atomicity). Default is pure round-robin.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [8*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]     ack,
  output logic [7:0]             tx_data,
  output logic                   tx_send,
  input  logic                   tx_ready,
  output logic                   busy,
  output logic [2:0]             gnt_id
);

  localparam int unsigned IDX_W = 3;

  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] rr_win;
  logic             rr_found;
  logic [IDX_W-1:0] win;
  logic [7:0]       win_byte;
  int unsigned      idx;

  // Round-robin search: first asserted req at or above ptr, wrapping to 0.
  always_comb begin
    rr_found = 1'b0;
    rr_win   = '0;
    idx      = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
        if (!rr_found && (j == idx) && req[j]) begin
          rr_found = 1'b1;
          rr_win   = IDX_W'(j);
        end
      end
    end
  end

`ifdef UART_ARB_LOCK_EN
  logic locked;
  logic lock_req;

  // Is the last winner still requesting?
  always_comb begin
    lock_req = 1'b0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (IDX_W'(j) == gnt_id) lock_req = req[j];
    end
  end

  assign win = (locked && lock_req) ? gnt_id : rr_win;

  // Lock is taken on every grant and dropped once the holder's req is low in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      locked <= 1'b0;
    end else if (state == IDLE) begin
      if (tx_ready && rr_found) locked <= 1'b1;
      else if (!lock_req)       locked <= 1'b0;
    end
  end
`else
  assign win = rr_win;
`endif

  // Byte of the selected requester.
  always_comb begin
    win_byte = 8'h00;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (IDX_W'(j) == win) win_byte = req_data[8*j +: 8];
    end
  end

  // Grant FSM with registered outputs; ack/tx_send default low each cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      ack     <= '0;
      tx_send <= 1'b0;
      tx_data <= 8'h00;
      gnt_id  <= '0;
      busy    <= 1'b0;
    end else begin
      ack     <= '0;
      tx_send <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_ready && rr_found) begin
            tx_data <= win_byte;
            tx_send <= 1'b1;
            ack     <= NUM_REQ'(1) << win;
            gnt_id  <= win;
            ptr     <= (win == IDX_W'(NUM_REQ - 1)) ? '0 : win + IDX_W'(1);
            busy    <= 1'b1;
            state   <= WAIT_BUSY;
          end
        end
        // uart_tx may take a cycle to drop ready after the strobe.
        WAIT_BUSY: begin
          if (!tx_ready) state <= WAIT_DONE;
        end
        // Return to IDLE only; the next grant is decided from IDLE.
        WAIT_DONE: begin
          if (tx_ready) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed testbench for uart_tx_arbiter with a simple uart_tx ready model
// and per-requester byte queues.
module tb_uart_tx_arbiter;

  localparam int FRAME = 8;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic [7:0]  tx_data;
  logic        tx_send;
  logic        tx_ready;
  logic        busy;
  logic [2:0]  gnt_id;

  int checks;
  int failures;

  uart_tx_arbiter #(.NUM_REQ(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_data (req_data),
    .ack      (ack),
    .tx_data  (tx_data),
    .tx_send  (tx_send),
    .tx_ready (tx_ready),
    .busy     (busy),
    .gnt_id   (gnt_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // uart_tx model: ready drops the cycle after a strobe for FRAME cycles.
  logic ready_en;
  int   frame_cnt = 0;
  always @(posedge clk) begin
    if (tx_send === 1'b1) frame_cnt <= FRAME;
    else if (frame_cnt > 0) frame_cnt <= frame_cnt - 1;
  end
  assign tx_ready = ready_en && (frame_cnt == 0);

  // Requester byte queues.
  logic [7:0] qmem [4][8];
  int         qhead [4];
  int         qlen  [4];

  // Send log.
  logic [7:0] l_data [16];
  logic [2:0] l_gnt  [16];
  logic [3:0] l_ack  [16];
  int         l_cyc  [16];
  int         l_n;
  int         stray;
  int         cyc;
  logic       prev_send;

  task automatic push(input int i, input logic [7:0] b);
    qmem[i][qhead[i] + qlen[i]] = b;
    qlen[i]++;
  endtask

  task automatic drive_req();
    for (int i = 0; i < 4; i++) begin
      req[i] = (qlen[i] > 0);
      req_data[8*i +: 8] = (qlen[i] > 0) ? qmem[i][qhead[i]] : 8'h00;
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    if (ack != 4'b0 && tx_send !== 1'b1) stray++;
    if (tx_send === 1'b1 && prev_send === 1'b1) stray++;
    prev_send = tx_send;
    if (tx_send === 1'b1 && l_n < 16) begin
      l_data[l_n] = tx_data;
      l_gnt[l_n]  = gnt_id;
      l_ack[l_n]  = ack;
      l_cyc[l_n]  = cyc;
      l_n++;
    end
    for (int i = 0; i < 4; i++) begin
      if (ack[i] === 1'b1 && qlen[i] > 0) begin
        qhead[i]++;
        qlen[i]--;
      end
    end
    drive_req();
  endtask

  task automatic run_until(input int n, input int max_cyc);
    int k;
    k = 0;
    while (l_n < n && k < max_cyc) begin
      step();
      k++;
    end
  endtask

  task automatic settle(input int n);
    repeat (n) step();
  endtask

  task automatic clear_log();
    l_n = 0;
    stray = 0;
    cyc = 0;
    prev_send = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ready_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      qhead[i] = 0;
      qlen[i] = 0;
    end
    drive_req();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_log();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ready_en = 1'b1;
    req = 4'b0;
    req_data = 32'h0;
    @(negedge clk);
    checks++; if (tx_send !== 1'b0) begin failures++; $display("FAIL rst_tx_send: got %b exp 0", tx_send); end
    checks++; if (ack !== 4'b0) begin failures++; $display("FAIL rst_ack: got %b exp 0000", ack); end
    checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL rst_tx_data: got %h exp 00", tx_data); end
    checks++; if (gnt_id !== 3'd0) begin failures++; $display("FAIL rst_gnt_id: got %0d exp 0", gnt_id); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b exp 0", busy); end

    do_reset();
    push(0, 8'h55);
    drive_req();
    run_until(1, 60);
    checks++; if (l_n !== 1) begin failures++; $display("FAIL rst_first_send: got %0d sends exp 1", l_n); end
    settle(3);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rst_busy_mid: got %b exp 1", busy); end

    // Reset in the middle of a frame, with a new request pending and uart not ready.
    ready_en = 1'b0;
    push(2, 8'h77);
    drive_req();
    #2 rst = 1'b1;
    #1;
    checks++; if (tx_send !== 1'b0) begin failures++; $display("FAIL midrst_tx_send: got %b exp 0", tx_send); end
    checks++; if (ack !== 4'b0) begin failures++; $display("FAIL midrst_ack: got %b exp 0000", ack); end
    checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL midrst_tx_data: got %h exp 00", tx_data); end
    checks++; if (gnt_id !== 3'd0) begin failures++; $display("FAIL midrst_gnt_id: got %0d exp 0", gnt_id); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b exp 0", busy); end
    @(negedge clk);
    rst = 1'b0;
    settle(10);
    checks++; if (l_n !== 1 || stray !== 0) begin failures++; $display("FAIL midrst_no_grant: got %0d sends %0d stray exp 1 0", l_n, stray); end
    ready_en = 1'b1;
    run_until(2, 60);
    checks++; if (l_n !== 2) begin failures++; $display("FAIL midrst_resume: got %0d sends exp 2", l_n); end
    checks++; if (l_data[1] !== 8'h77 || l_gnt[1] !== 3'd2 || l_ack[1] !== 4'b0100) begin
      failures++; $display("FAIL midrst_grant: got %h/%0d/%b exp 77/2/0100", l_data[1], l_gnt[1], l_ack[1]);
    end
  endtask

  task automatic test_single();
    do_reset();
    push(2, 8'h48);
    drive_req();
    run_until(1, 60);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy: got %b exp 1", busy); end
    settle(30);
    checks++; if (l_n !== 1) begin failures++; $display("FAIL single_count: got %0d exp 1", l_n); end
    checks++; if (l_data[0] !== 8'h48) begin failures++; $display("FAIL single_data: got %h exp 48", l_data[0]); end
    checks++; if (l_ack[0] !== 4'b0100) begin failures++; $display("FAIL single_ack: got %b exp 0100", l_ack[0]); end
    checks++; if (l_gnt[0] !== 3'd2) begin failures++; $display("FAIL single_gnt: got %0d exp 2", l_gnt[0]); end
    checks++; if (busy !== 1'b0 || tx_data !== 8'h48) begin failures++; $display("FAIL single_idle: got busy %b data %h exp 0 48", busy, tx_data); end
    checks++; if (stray !== 0) begin failures++; $display("FAIL single_stray: got %0d exp 0", stray); end
  endtask

  // Runs directly after test_single, so the pointer sits at 3.
  task automatic test_wrap();
    clear_log();
    push(0, 8'h30);
    push(1, 8'h31);
    drive_req();
    run_until(2, 80);
    checks++; if (l_n !== 2) begin failures++; $display("FAIL wrap_count: got %0d exp 2", l_n); end
    checks++; if (l_gnt[0] !== 3'd0 || l_data[0] !== 8'h30) begin failures++; $display("FAIL wrap_first: got %0d/%h exp 0/30", l_gnt[0], l_data[0]); end
    checks++; if (l_gnt[1] !== 3'd1 || l_data[1] !== 8'h31) begin failures++; $display("FAIL wrap_second: got %0d/%h exp 1/31", l_gnt[1], l_data[1]); end
  endtask

  task automatic test_contention();
    logic [7:0] exp_d [5];
    logic [2:0] exp_g [5];
`ifdef UART_ARB_LOCK_EN
    exp_d = '{8'h41, 8'h41, 8'h42, 8'h43, 8'h44};
    exp_g = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3};
`else
    exp_d = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h41};
    exp_g = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
`endif
    do_reset();
    push(0, 8'h41); push(0, 8'h41);
    push(1, 8'h42);
    push(2, 8'h43);
    push(3, 8'h44);
    drive_req();
    run_until(5, 200);
    settle(30);
    checks++; if (l_n !== 5) begin failures++; $display("FAIL cont_count: got %0d exp 5", l_n); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (l_data[i] !== exp_d[i] || l_gnt[i] !== exp_g[i] || l_ack[i] !== (4'b0001 << exp_g[i])) begin
        failures++;
        $display("FAIL cont_send%0d: got %h/%0d/%b exp %h/%0d", i, l_data[i], l_gnt[i], l_ack[i], exp_d[i], exp_g[i]);
      end
    end
    for (int i = 1; i < 5; i++) begin
      checks++;
      if (l_cyc[i] - l_cyc[i-1] < FRAME + 2) begin
        failures++; $display("FAIL cont_spacing%0d: got %0d cycles exp >= %0d", i, l_cyc[i] - l_cyc[i-1], FRAME + 2);
      end
    end
    checks++; if (stray !== 0) begin failures++; $display("FAIL cont_stray: got %0d exp 0", stray); end
  endtask

  task automatic test_lock();
    logic [7:0] exp_d [4];
`ifdef UART_ARB_LOCK_EN
    exp_d = '{8'h48, 8'h69, 8'h21, 8'h58};
`else
    exp_d = '{8'h48, 8'h58, 8'h69, 8'h21};
`endif
    do_reset();
    push(0, 8'h48); push(0, 8'h69); push(0, 8'h21);
    push(1, 8'h58);
    drive_req();
    run_until(4, 200);
    settle(30);
    checks++; if (l_n !== 4) begin failures++; $display("FAIL lock_count: got %0d exp 4", l_n); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (l_data[i] !== exp_d[i]) begin
        failures++; $display("FAIL lock_send%0d: got %h exp %h", i, l_data[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_drop();
    do_reset();
    push(0, 8'h11);
    drive_req();
    run_until(1, 60);
    settle(3);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL drop_busy: got %b exp 1", busy); end
    push(1, 8'h22);
    drive_req();
    step();
    qlen[1] = 0;
    drive_req();
    settle(40);
    checks++; if (l_n !== 1) begin failures++; $display("FAIL drop_count: got %0d exp 1", l_n); end
    checks++; if (l_ack[0] !== 4'b0001) begin failures++; $display("FAIL drop_ack: got %b exp 0001", l_ack[0]); end
    checks++; if (stray !== 0) begin failures++; $display("FAIL drop_stray: got %0d exp 0", stray); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    for (int i = 0; i < 4; i++) begin
      qhead[i] = 0;
      qlen[i] = 0;
    end
    clear_log();
    test_reset();
    test_single();
    test_wrap();
    test_contention();
    test_lock();
    test_drop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of byte requesters (2..8).
REQ-002 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port req  input  NUM_REQ  level request per requester; byte valid while high.
REQ-005 SHALL have port req_data  input  8*NUM_REQ  byte of requester i on bits [8i+7:8i].
REQ-006 SHALL have port ack  output  NUM_REQ  one-hot, one-cycle pulse: requester's byte taken.
REQ-007 SHALL have port tx_data  output  8  byte to uart_tx data input, registered.
REQ-008 SHALL have port tx_send  output  1  one-cycle send strobe to uart_tx.
REQ-009 SHALL have port tx_ready  input  1  uart_tx ready; low while a frame is in progress.
REQ-010 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-011 SHALL have port gnt_id  output  3  index of last granted requester.

Function
REQ-012 SHALL implement FSM states IDLE, WAIT_BUSY, WAIT_DONE.
REQ-013 In IDLE with tx_ready=1 and req!=0 at edge T, SHALL select a winner; at T+1: tx_data=winner byte, tx_send=1, ack[winner]=1, gnt_id=winner, state=WAIT_BUSY.
REQ-014 tx_send and ack SHALL be high exactly one cycle per grant; tx_data SHALL hold until the next grant.
REQ-015 Winner SHALL be the first asserted req at or above round-robin pointer ptr, searching upward with wrap from NUM_REQ-1 to 0.
REQ-016 ptr SHALL become (winner+1) mod NUM_REQ on each grant.
REQ-017 WAIT_BUSY SHALL advance to WAIT_DONE on the first cycle tx_ready=0.
REQ-018 WAIT_DONE SHALL return to IDLE on the first cycle tx_ready=1; no grant in that same cycle.
REQ-019 In IDLE with tx_ready=0, SHALL not grant.
REQ-020 req changes while not in IDLE SHALL be ignored; a req dropped before grant SHALL never be acked.
REQ-021 A requester SHALL present its next byte or drop req in the cycle after its ack; the block grants at most once per frame.
REQ-022 Minimum spacing between tx_send pulses SHALL be one full uart_tx frame plus 2 cycles.

Reset
REQ-023 On rst high, immediately: state=IDLE, ptr=0, ack=0, tx_send=0, tx_data=8'h00, gnt_id=0, busy=0.
REQ-024 Reset mid-frame SHALL abandon the grant without ack re-issue; after release no grant until tx_ready=1.

Configuration
REQ-025 Macro UART_ARB_LOCK_EN SHALL select grant locking.
REQ-026 With UART_ARB_LOCK_EN defined: if gnt_id's req is still high on return to IDLE, that requester SHALL be granted again regardless of ptr (message atomicity); lock releases when its req is low in IDLE.
REQ-027 Without UART_ARB_LOCK_EN: pure round-robin per REQ-015, one byte per grant.

Verification
REQ-028 Reset: rst pulse mid-operation -> all outputs 0, state IDLE within same cycle, no ack afterwards until tx_ready=1.
REQ-029 Single request: req=4'b0100, byte 8'h48 -> one tx_send, tx_data=8'h48, ack=4'b0100, gnt_id=2, ptr=3.
REQ-030 Contention, lock off: req=4'b1111 held, bytes "A","B","C","D" -> send order A,B,C,D,A with one frame between sends.
REQ-031 Wrap: ptr=3, req=4'b0011 -> requester 0 granted, then 1.
REQ-032 Lock on: req=4'b0011, requester 0 holds req for 3 bytes "H","i","!" -> all three sent before requester 1's byte.
REQ-033 Drop: req[1] pulsed low-high-low while busy -> no ack[1], no extra tx_send.
